// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU control codes, arbiter state type and ctrl legality helper
package alu_pkg;

    typedef logic [2:0] alu_ctrl_t;

    localparam alu_ctrl_t ALU_ADD = 3'b000;
    localparam alu_ctrl_t ALU_SUB = 3'b001;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } arb_state_t;

    // The ALU only implements add and subtract; anything else returns zero
    function automatic logic is_legal_ctrl(input alu_ctrl_t ctrl);
        return (ctrl == ALU_ADD) || (ctrl == ALU_SUB);
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - requester, ALU and response bundle between arbiter and its environment
interface alu_arbiter_if
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int WIDTH   = 32,
    parameter int ID_W    = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_op1;
    logic [NUM_REQ*WIDTH-1:0] req_op2;
    logic [NUM_REQ*3-1:0]     req_ctrl;

    logic [WIDTH-1:0]         alu_op1;
    logic [WIDTH-1:0]         alu_op2;
    alu_ctrl_t                alu_ctrl;
    logic [WIDTH-1:0]         alu_result;
    logic                     alu_eq;

    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [WIDTH-1:0]         rsp_data;
    logic                     rsp_eq;
    logic [ID_W-1:0]          rsp_id;
    logic                     rsp_illegal;

    // Environment side: requesters, the ALU itself and the response consumer
    modport master (
        output req_valid, req_op1, req_op2, req_ctrl,
        output alu_result, alu_eq,
        output rsp_ready,
        input  req_ready,
        input  alu_op1, alu_op2, alu_ctrl,
        input  rsp_valid, rsp_data, rsp_eq, rsp_id, rsp_illegal
    );

    // Arbiter side
    modport slave (
        input  req_valid, req_op1, req_op2, req_ctrl,
        input  alu_result, alu_eq,
        input  rsp_ready,
        output req_ready,
        output alu_op1, alu_op2, alu_ctrl,
        output rsp_valid, rsp_data, rsp_eq, rsp_id, rsp_illegal
    );

endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin grant starting one past the previous winner
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    last_grant_i,
    input  logic               enable_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [ID_W-1:0]    grant_idx_o,
    output logic               grant_valid_o
);

    int   idx;
    logic found;

    // Scan last+1, last+2, ... modulo NUM_REQ and take the first pending request
    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        idx         = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_grant_i) + k) % NUM_REQ;
            if (enable_i && !found && req_i[idx]) begin
                found        = 1'b1;
                grant_o[idx] = 1'b1;
                grant_idx_o  = ID_W'(idx);
            end
        end
        grant_valid_o = found;
    end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - shares one combinational ALU between requesters with a registered response slot
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int WIDTH   = 32,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic         clk,
    input  logic         rst,
    alu_arbiter_if.slave bus
);

    arb_state_t          state_q, state_d;
    logic [ID_W-1:0]     last_grant_q, last_grant_d;
    logic [WIDTH-1:0]    rsp_data_q, rsp_data_d;
    logic                rsp_eq_q, rsp_eq_d;
    logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
    logic                rsp_illegal_q, rsp_illegal_d;

    logic                can_issue;
    logic                issue;
    logic [NUM_REQ-1:0]  grant;
    logic [ID_W-1:0]     grant_idx;
    logic [WIDTH-1:0]    sel_op1;
    logic [WIDTH-1:0]    sel_op2;
    alu_ctrl_t           sel_ctrl;

    // Slot can take a new result if empty or being drained this cycle; nothing issues in reset
    assign can_issue = !rst && ((state_q == IDLE) || bus.rsp_ready);

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr (
        .req_i         (bus.req_valid),
        .last_grant_i  (last_grant_q),
        .enable_i      (can_issue),
        .grant_o       (grant),
        .grant_idx_o   (grant_idx),
        .grant_valid_o (issue)
    );

    // AND-OR mux of the granted requester's fields; all-zero when nothing is granted
    always_comb begin
        sel_op1  = '0;
        sel_op2  = '0;
        sel_ctrl = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_op1  = sel_op1  | bus.req_op1[i*WIDTH +: WIDTH];
                sel_op2  = sel_op2  | bus.req_op2[i*WIDTH +: WIDTH];
                sel_ctrl = sel_ctrl | bus.req_ctrl[i*3 +: 3];
            end
        end
    end

    assign bus.req_ready = grant;
    assign bus.alu_op1   = sel_op1;
    assign bus.alu_op2   = sel_op2;
    assign bus.alu_ctrl  = sel_ctrl;

    // Next state and response capture: an issue always fills the slot, a drain without issue empties it
    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        rsp_data_d    = rsp_data_q;
        rsp_eq_d      = rsp_eq_q;
        rsp_id_d      = rsp_id_q;
        rsp_illegal_d = rsp_illegal_q;
        if (issue) begin
            state_d       = RESP;
            last_grant_d  = grant_idx;
            rsp_data_d    = bus.alu_result;
            rsp_eq_d      = bus.alu_eq;
            rsp_id_d      = grant_idx;
            rsp_illegal_d = !is_legal_ctrl(sel_ctrl);
        end else if ((state_q == RESP) && bus.rsp_ready) begin
            state_d = IDLE;
        end
    end

    // State and response slot registers; priority pointer resets so requester 0 wins first
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            last_grant_q  <= ID_W'(NUM_REQ - 1);
            rsp_data_q    <= '0;
            rsp_eq_q      <= 1'b0;
            rsp_id_q      <= '0;
            rsp_illegal_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            rsp_data_q    <= rsp_data_d;
            rsp_eq_q      <= rsp_eq_d;
            rsp_id_q      <= rsp_id_d;
            rsp_illegal_q <= rsp_illegal_d;
        end
    end

    assign bus.rsp_valid   = (state_q == RESP);
    assign bus.rsp_data    = rsp_data_q;
    assign bus.rsp_eq      = rsp_eq_q;
    assign bus.rsp_id      = rsp_id_q;
    assign bus.rsp_illegal = rsp_illegal_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed and random checks of alu_arbiter against a reference model
module tb_alu_arbiter;

    localparam int NR = 2;
    localparam int W  = 32;
    localparam int IW = 1;

    logic clk;
    logic rst;

    alu_arbiter_if #(.NUM_REQ(NR), .WIDTH(W), .ID_W(IW)) bif ();

    alu_arbiter #(.NUM_REQ(NR), .WIDTH(W), .ID_W(IW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External ALU: add, subtract, anything else yields zero
    function automatic logic [W:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] c);
        logic [W-1:0] r;
        logic         e;
        r = '0;
        e = 1'b0;
        if (c == 3'b000) begin
            r = a + b;
            e = (a == b);
        end else if (c == 3'b001) begin
            r = a - b;
            e = (a == b);
        end
        return {e, r};
    endfunction

    logic [W:0] alu_out;
    assign alu_out        = alu_fn(bif.alu_op1, bif.alu_op2, bif.alu_ctrl);
    assign bif.alu_result = alu_out[W-1:0];
    assign bif.alu_eq     = alu_out[W];

    int total = 0;
    int bad   = 0;

    // Requester and consumer stimulus
    logic         vld [NR];
    logic [W-1:0] op1 [NR];
    logic [W-1:0] op2 [NR];
    logic [2:0]   ctl [NR];
    logic         rr;
    int           acc;

    // Reference model of the response slot and rotation pointer
    logic         m_valid;
    logic [W-1:0] m_data;
    logic         m_eq;
    int           m_id;
    logic         m_ill;
    int           m_last;
    logic [W-1:0] held_data;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = '0;
        m_eq    = 1'b0;
        m_id    = 0;
        m_ill   = 1'b0;
        m_last  = NR - 1;
    endtask

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            bif.req_valid[i]        = vld[i];
            bif.req_op1[i*W +: W]   = op1[i];
            bif.req_op2[i*W +: W]   = op2[i];
            bif.req_ctrl[i*3 +: 3]  = ctl[i];
        end
        bif.rsp_ready = rr;
    endtask

    task automatic set_req(input int i, input logic v, input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] c);
        vld[i] = v;
        op1[i] = a;
        op2[i] = b;
        ctl[i] = c;
    endtask

    // One clock: drive, check at the falling edge, advance the model, then step past the rising edge
    task automatic cycle();
        int           g;
        bit           can;
        logic [NR-1:0] er;
        logic [W-1:0] e1;
        logic [W-1:0] e2;
        logic [2:0]   ec;
        logic [W:0]   res;
        drive();
        @(negedge clk);
        can = !m_valid || rr;
        g   = -1;
        if (can) begin
            for (int k = 1; k <= NR; k++) begin
                int i;
                i = (m_last + k) % NR;
                if (g < 0 && vld[i]) g = i;
            end
        end
        er = '0;
        e1 = '0;
        e2 = '0;
        ec = '0;
        if (g >= 0) begin
            er[g] = 1'b1;
            e1    = op1[g];
            e2    = op2[g];
            ec    = ctl[g];
        end
        check("req_ready",   64'(bif.req_ready),   64'(er));
        check("alu_op1",     64'(bif.alu_op1),     64'(e1));
        check("alu_op2",     64'(bif.alu_op2),     64'(e2));
        check("alu_ctrl",    64'(bif.alu_ctrl),    64'(ec));
        check("rsp_valid",   64'(bif.rsp_valid),   64'(m_valid));
        check("rsp_data",    64'(bif.rsp_data),    64'(m_data));
        check("rsp_eq",      64'(bif.rsp_eq),      64'(m_eq));
        check("rsp_id",      64'(bif.rsp_id),      64'(m_id));
        check("rsp_illegal", 64'(bif.rsp_illegal), 64'(m_ill));
        if (g >= 0) begin
            if (ctl[g] == 3'b000) res = {(op1[g] == op2[g]), op1[g] + op2[g]};
            else if (ctl[g] == 3'b001) res = {(op1[g] == op2[g]), op1[g] - op2[g]};
            else res = '0;
            m_data  = res[W-1:0];
            m_eq    = res[W];
            m_id    = g;
            m_ill   = !(ctl[g] == 3'b000 || ctl[g] == 3'b001);
            m_last  = g;
            m_valid = 1'b1;
        end else if (can) begin
            m_valid = 1'b0;
        end
        acc = g;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #1;
        check("rst_async_valid", 64'(bif.rsp_valid), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        rst = 1'b1;
        rr  = 1'b0;
        acc = -1;
        held_data = '0;
        for (int i = 0; i < NR; i++) set_req(i, 1'b1, 32'h11 + W'(i), 32'h22, 3'b000);
        drive();
        model_reset();

        // Reset state, with requests pending to show that nothing is granted during reset
        @(posedge clk);
        @(posedge clk);
        #2;
        check("rst_req_ready",   64'(bif.req_ready),   64'd0);
        check("rst_alu_op1",     64'(bif.alu_op1),     64'd0);
        check("rst_alu_ctrl",    64'(bif.alu_ctrl),    64'd0);
        check("rst_rsp_valid",   64'(bif.rsp_valid),   64'd0);
        check("rst_rsp_data",    64'(bif.rsp_data),    64'd0);
        check("rst_rsp_id",      64'(bif.rsp_id),      64'd0);
        check("rst_rsp_illegal", 64'(bif.rsp_illegal), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single add from requester 0
        set_req(0, 1'b1, 32'd5, 32'd7, 3'b000);
        set_req(1, 1'b0, 32'd0, 32'd0, 3'b000);
        rr = 1'b1;
        cycle();
        check("t1_accept", 64'(acc), 64'd0);
        set_req(0, 1'b0, 32'd0, 32'd0, 3'b000);
        cycle();
        check("t1_data", 64'(bif.rsp_data), 64'd12);
        cycle();

        // Both requesters always valid: grants alternate starting with requester 0 after reset
        pulse_reset();
        set_req(0, 1'b1, 32'd9, 32'd9, 3'b001);
        set_req(1, 1'b1, 32'd3, 32'd4, 3'b000);
        for (int n = 0; n < 4; n++) begin
            cycle();
            check("alt_grant", 64'(acc), 64'(n % 2));
        end
        set_req(0, 1'b0, 32'd0, 32'd0, 3'b000);
        set_req(1, 1'b0, 32'd0, 32'd0, 3'b000);
        cycle();
        check("alt_last_data", 64'(bif.rsp_data), 64'd7);

        // Backpressure: response held while requester 1 waits
        set_req(0, 1'b1, 32'd40, 32'd2, 3'b001);
        cycle();
        set_req(0, 1'b0, 32'd0, 32'd0, 3'b000);
        set_req(1, 1'b1, 32'd100, 32'd23, 3'b000);
        rr = 1'b0;
        held_data = bif.rsp_data;
        for (int n = 0; n < 3; n++) begin
            cycle();
            check("bp_hold", 64'(bif.rsp_data), 64'(held_data));
        end
        rr = 1'b1;
        cycle();
        check("bp_release_accept", 64'(acc), 64'd1);
        set_req(1, 1'b0, 32'd0, 32'd0, 3'b000);
        cycle();
        check("bp_new_data", 64'(bif.rsp_data), 64'd123);

        // Illegal control code
        set_req(0, 1'b1, 32'd1, 32'd2, 3'b101);
        cycle();
        set_req(0, 1'b0, 32'd0, 32'd0, 3'b000);
        cycle();
        check("ill_flag", 64'(bif.rsp_illegal), 64'd1);

        // Subtract wrap-around
        set_req(1, 1'b1, 32'd0, 32'd1, 3'b001);
        cycle();
        set_req(1, 1'b0, 32'd0, 32'd0, 3'b000);
        cycle();
        check("sub_wrap", 64'(bif.rsp_data), 64'hFFFF_FFFF);

        // Asynchronous reset while a response is pending
        set_req(1, 1'b1, 32'd8, 32'd8, 3'b000);
        rr = 1'b0;
        cycle();
        set_req(1, 1'b0, 32'd0, 32'd0, 3'b000);
        cycle();
        check("pre_rst_valid", 64'(bif.rsp_valid), 64'd1);
        set_req(0, 1'b1, 32'd6, 32'd1, 3'b001);
        set_req(1, 1'b1, 32'd2, 32'd2, 3'b000);
        drive();
        #3;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 64'(bif.rsp_valid), 64'd0);
        check("mid_rst_ready", 64'(bif.req_ready), 64'd0);
        check("mid_rst_op1",   64'(bif.alu_op1),   64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        rr = 1'b1;
        cycle();
        check("post_rst_first_grant", 64'(acc), 64'd0);

        // Randomized traffic; requests hold until accepted
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NR; i++) begin
                if (acc == i || !vld[i]) begin
                    logic [W-1:0] a;
                    logic [2:0]   c;
                    int           r;
                    a = $urandom;
                    r = $urandom_range(0, 5);
                    c = (r < 2) ? 3'b000 : (r < 4) ? 3'b001 : 3'($urandom_range(2, 7));
                    set_req(i, 1'($urandom_range(0, 1)), a, ($urandom_range(0, 3) == 0) ? a : W'($urandom), c);
                end
            end
            rr = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
